// File: rtl/riscv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_pkg : shared types and constants for the RISC-V instruction fetch unit
// Revision  : 1.0
// ----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/riscv_fetch_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_fetch_buffer : 2-entry FIFO of fetched {instr, pc} pairs
// Revision           : 1.0
// ----------------------------------------------------------------------------
module riscv_fetch_buffer
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic [1:0]   occupancy
);

  fetch_entry_t entries [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         do_pop;
  logic         do_push;

  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign full      = (count == 2'd2);
  assign occupancy = count;
  assign head      = entries[rd_ptr];

  // Entries are reset so the idle outputs show a defined {0, RESET_PC}.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries[0] <= '{instr: '0, pc: RESET_PC};
      entries[1] <= '{instr: '0, pc: RESET_PC};
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_fetch_unit : single-outstanding instruction fetch with redirect/flush
// Revision         : 1.0
// ----------------------------------------------------------------------------
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  input  logic            i_ready
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_next;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] addr_next;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] addr_plus4;
  logic            push;
  logic            pop;
  logic            full;
  logic [1:0]      occupancy;
  logic [2:0]      occ_after;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign imem_req        = (state == REQ) || (state == FLUSH);
  assign imem_addr       = addr_q;
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign addr_plus4      = addr_q + XLEN'(INSTR_BYTES);

  assign pop        = o_valid && i_ready;
  assign push       = (state == REQ) && imem_ack && !redirect;
  assign push_entry = '{instr: imem_rdata, pc: addr_q};
  assign occ_after  = {1'b0, occupancy} + {2'b00, push} - {2'b00, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      addr_q   <= addr_next;
    end
  end

  // Redirect wins over push/pop; an in-flight request must still complete
  // before the new target can be issued, since imem_addr is held until ack.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    addr_next     = addr_q;
    if (redirect) begin
      fetch_pc_next = redirect_target;
      case (state)
        IDLE: begin
          state_next = REQ;
          addr_next  = redirect_target;
        end
        REQ, FLUSH: begin
          if (imem_ack) begin
            state_next = REQ;
            addr_next  = redirect_target;
          end else begin
            state_next = FLUSH;
          end
        end
        default: state_next = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (!(full && !pop)) begin
            state_next = REQ;
            addr_next  = fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc_next = addr_plus4;
            if (occ_after <= 3'd1) begin
              addr_next = addr_plus4;
            end else begin
              state_next = IDLE;
            end
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            state_next = REQ;
            addr_next  = fetch_pc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  riscv_fetch_buffer #(
    .RESET_PC (RESET_PC)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head       (head),
    .full       (full),
    .occupancy  (occupancy)
  );

  assign o_valid    = (occupancy != 2'd0);
  assign o_instr    = head.instr;
  assign o_pc       = head.pc;
  assign o_pc_plus4 = head.pc + XLEN'(INSTR_BYTES);

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_riscv_fetch_unit : scoreboard bench for riscv_fetch_unit
// Revision            : 1.0
// ----------------------------------------------------------------------------
module tb_riscv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        i_ready = 1'b0;

  logic        mem_auto  = 1'b1;
  logic        man_ack   = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic        mem_ack   = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  int          mem_lat   = 0;
  int          mem_cnt   = 0;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] exp_q [$];
  int          pop_cyc [$];
  logic [31:0] mon_e;

  localparam logic [31:0] BAD_WORD = 32'hBAD0_BAD0;

  always #5 clk = ~clk;

  assign imem_ack   = mem_auto ? mem_ack : man_ack;
  assign imem_rdata = mem_auto ? mem_rdata : man_rdata;

  riscv_fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .o_valid     (o_valid),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .o_pc_plus4  (o_pc_plus4),
    .i_ready     (i_ready)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks mem_lat cycles after a request is first seen.
  always @(negedge clk) begin
    if (!imem_req) begin
      mem_cnt   = 0;
      mem_ack   = 1'b0;
      mem_rdata = BAD_WORD;
    end else begin
      if (mem_ack) mem_cnt = 0;
      if (mem_cnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = word_at(imem_addr);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = BAD_WORD;
      end
      mem_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted instruction is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual_pc=%h required=none", o_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_pc", o_pc, mon_e);
        check("out_instr", o_instr, word_at(mon_e));
        check("out_pc_plus4", o_pc_plus4, mon_e + 32'd4);
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    i_ready  = 1'b0;
    redirect = 1'b0;
    mem_auto = 1'b1;
    repeat (2) tick();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s actual_left=%0d required_left=0", name, exp_q.size());
      exp_q.delete();
    end
    i_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    apply_reset();
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_o_valid", 32'(o_valid), 32'h0);
    check("rst_o_instr", o_instr, 32'h0);
    check("rst_o_pc", o_pc, 32'h0);
    check("rst_o_pc_plus4", o_pc_plus4, 32'h4);
    check("rst_imem_addr", imem_addr, 32'h0);

    // Zero-wait streaming: one instruction per clock
    mem_lat = 0;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    pop_cyc.delete();
    i_ready = 1'b1;
    rst = 1'b0;
    tick();
    check("first_req", 32'(imem_req), 32'h1);
    check("first_addr", imem_addr, 32'h0);
    drain("stream", 40);
    checks++;
    if (pop_cyc.size() != 4 || pop_cyc[3] - pop_cyc[0] != 3) begin
      failures++;
      $display("FAIL throughput actual_pops=%0d required_pops=4 over 4 cycles", pop_cyc.size());
    end

    // Delayed ack: request held, valid the cycle after ack
    apply_reset();
    mem_lat = 3;
    exp_q = '{32'h0, 32'h4};
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_req", 32'(imem_req), 32'h1);
      check("wait_addr", imem_addr, 32'h0);
    end
    tick();
    check("ack_cycle_valid", 32'(o_valid), 32'h0);
    tick();
    check("after_ack_valid", 32'(o_valid), 32'h1);
    check("after_ack_pc", o_pc, 32'h0);
    i_ready = 1'b1;
    drain("delayed", 60);

    // Back-pressure: buffer fills, requests stop, then resume
    apply_reset();
    mem_lat = 0;
    exp_q = '{32'h0, 32'h4, 32'h8};
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= 4) begin
        check("stall_valid", 32'(o_valid), 32'h1);
        check("stall_pc", o_pc, 32'h0);
        check("stall_req", 32'(imem_req), 32'h0);
      end
    end
    i_ready = 1'b1;
    drain("stall", 40);

    // Redirect while ack pending: stale word discarded, target aligned
    apply_reset();
    mem_lat = 3;
    exp_q = '{32'h0000_1000, 32'h0000_1004};
    i_ready = 1'b1;
    rst = 1'b0;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1003;
    tick();
    redirect = 1'b0;
    check("flush_req", 32'(imem_req), 32'h1);
    check("flush_addr", imem_addr, 32'h0);
    check("flush_valid", 32'(o_valid), 32'h0);
    tick();
    check("flush_addr_hold", imem_addr, 32'h0);
    drain("redirect", 60);

    // Wrap at top of address space, redirect from IDLE
    apply_reset();
    mem_lat = 0;
    exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    i_ready = 1'b1;
    rst = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_next_addr", imem_addr, 32'h0);
    drain("wrap", 40);

    // Reset mid-request with a late ack afterwards
    apply_reset();
    mem_auto = 1'b0;
    man_ack  = 1'b0;
    mem_lat  = 0;
    exp_q = '{32'h0, 32'h4};
    i_ready = 1'b1;
    rst = 1'b0;
    tick();
    check("pre_rst_req", 32'(imem_req), 32'h1);
    rst = 1'b1;
    tick();
    check("in_rst_req", 32'(imem_req), 32'h0);
    rst       = 1'b0;
    man_ack   = 1'b1;
    man_rdata = 32'h1234_5678;
    tick();
    man_ack  = 1'b0;
    mem_auto = 1'b1;
    check("late_ack_valid", 32'(o_valid), 32'h0);
    check("refetch_req", 32'(imem_req), 32'h1);
    check("refetch_addr", imem_addr, 32'h0);
    drain("late_ack", 40);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/riscv_fetch_unit.md
RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 imem_ack  in  1  memory has returned imem_rdata; sampled only while imem_req=1.
REQ-007 imem_rdata  in  32  fetched instruction word, valid when imem_ack=1.
REQ-008 redirect  in  1  one-cycle pulse from branch/jump resolution.
REQ-009 redirect_pc  in  32  new fetch target, valid when redirect=1.
REQ-010 o_valid  out  1  o_instr/o_pc/o_pc_plus4 hold a valid instruction.
REQ-011 o_instr  out  32  instruction delivered to the datapath (decode/register-bank fields).
REQ-012 o_pc  out  32  address of o_instr.
REQ-013 o_pc_plus4  out  32  o_pc+4, modulo 2^32.
REQ-014 i_ready  in  1  datapath accepts the head instruction; transfer when o_valid & i_ready.

Function
REQ-015 States SHALL be IDLE (no request outstanding), REQ (request outstanding), FLUSH (outstanding request whose data is discarded).
REQ-016 At most one memory request SHALL be outstanding; imem_req = (state==REQ or state==FLUSH).
REQ-017 Once asserted, imem_req and imem_addr SHALL stay stable until the cycle imem_ack=1, including across redirect.
REQ-018 imem_ack in the same cycle imem_req first rises (zero-wait memory) SHALL be legal and accepted.
REQ-019 Output buffer: 2-entry FIFO of {instr, pc}; o_valid = (occupancy>0); outputs show the head entry.
REQ-020 IDLE->REQ when occupancy after this cycle's pop is <=1; imem_addr <= fetch pc.
REQ-021 REQ with imem_ack: push {imem_rdata, imem_addr}; fetch pc <= imem_addr+4 (wraps 32'hFFFF_FFFC->0); stay REQ at new address if post-push/pop occupancy <=1, else IDLE.
REQ-022 Push and pop in one cycle SHALL leave occupancy unchanged; sustained throughput SHALL be one instruction per clock with zero-wait memory and i_ready=1.
REQ-023 redirect SHALL take priority over push and pop: FIFO cleared (o_valid=0 next cycle); fetch pc <= {redirect_pc[31:2],2'b00}.
REQ-024 redirect in REQ without imem_ack -> FLUSH; with imem_ack -> data discarded, REQ at the redirect target next cycle.
REQ-025 FLUSH: on imem_ack discard data and go REQ at the redirect target; further redirect in FLUSH updates target only.
REQ-026 redirect in IDLE -> REQ at the redirect target next cycle.
REQ-027 An instruction fetched from a pre-redirect address SHALL never appear with o_valid=1 after the redirect.
REQ-028 When occupancy is 2 and i_ready=0, outputs SHALL hold stable and no new request SHALL issue.

Reset
REQ-029 While rst=1 at a clock edge: state<=IDLE, occupancy<=0, fetch pc<=RESET_PC.
REQ-030 Reset outputs: imem_req=0, o_valid=0, o_instr=0, o_pc=RESET_PC, o_pc_plus4=RESET_PC+4, imem_addr=RESET_PC.
REQ-031 rst mid-request SHALL abandon the outstanding request; a late imem_ack after reset, with imem_req=0, SHALL be ignored.
REQ-032 First imem_req SHALL assert in the first cycle after rst deasserts.

Structure
REQ-033 riscv_pkg SHALL hold fetch_state_t (IDLE/REQ/FLUSH), XLEN=32, INSTR_BYTES=4, and the fetch entry struct {instr, pc}.
REQ-034 The 2-entry FIFO SHALL be a sub-module riscv_fetch_buffer (push, pop, flush, full, occupancy); FSM and PC stay in riscv_fetch_unit.
REQ-035 No combinational path from i_ready or redirect to imem_addr.

Verification
REQ-036 Zero-wait memory, i_ready=1 -> o_pc sequence 0,4,8,12 on consecutive cycles, one per clock.
REQ-037 Ack delayed 3 cycles -> imem_req/imem_addr=0x0 held 3 cycles; o_valid rises the cycle after ack with o_pc=0x0.
REQ-038 i_ready=0 for 10 cycles -> occupancy 2, o_pc=0x0 stable, imem_req=0 after second ack; i_ready=1 resumes 0x4, 0x8.
REQ-039 Redirect to 0x0000_1003 while ack pending -> FLUSH; discarded word never valid; next o_pc=0x1000.
REQ-040 Fetch at 0xFFFF_FFFC -> o_pc_plus4=0x0 and next fetch address 0x0.
REQ-041 rst pulsed while imem_req=1 with ack arriving the following cycle -> o_valid stays 0; refetch from RESET_PC.
